// File: rtl/generic_2clk_fifo_wr_arb.sv
// ============================================================================
// Module   : generic_2clk_fifo_wr_arb
// Function : Round-robin write-port arbiter for a generic 2clk FIFO envelope;
//            grants are gated on FIFO headroom. Optional burst lock via macro
//            GENERIC_2CLK_FIFO_WR_ARB_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module generic_2clk_fifo_wr_arb #(
    parameter int NUM_REQ        = 4,
    parameter int DAT_WIDTH      = 36,
    parameter int PTR_WIDTH      = 5,
    parameter int NUM_OF_ENTRIES = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arb_en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         wr_op,
    output logic [DAT_WIDTH-1:0]         wr_data,
    output logic [DAT_WIDTH-1:0]         wr_mask,
    input  logic [PTR_WIDTH:0]           wr_entry_used,
    input  logic                         wr_full_err,
    output logic                         arb_err
);

    localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 OCC_W    = PTR_WIDTH + 2;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [OCC_W-1:0]   DEPTH    = OCC_W'(NUM_OF_ENTRIES);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_cand;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;
    logic [OCC_W-1:0] occupancy;
    logic             headroom;
    logic             grant_any;
    logic [IDX_W-1:0] gnt_idx;
    logic             ptr_advance;

    // The in-flight write is counted so a full FIFO is never overrun.
    assign occupancy = {1'b0, wr_entry_used} + {{(OCC_W-1){1'b0}}, wr_op};
    assign headroom  = (occupancy < DEPTH);
    assign wr_mask   = '1;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_cand = (rr_cand == LAST_IDX) ? '0 : rr_cand + 1'b1;
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

`ifdef GENERIC_2CLK_FIFO_WR_ARB_BURST_EN
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] lock_idx_nxt;

    always_comb begin
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        grant_any    = 1'b0;
        gnt_idx      = rr_idx;
        ptr_advance  = 1'b0;
        case (state)
            ARB: begin
                grant_any   = !reset && arb_en && rr_found && headroom;
                gnt_idx     = rr_idx;
                ptr_advance = grant_any;
                if (grant_any && !req_last[rr_idx]) begin
                    state_nxt    = LOCK;
                    lock_idx_nxt = rr_idx;
                end
            end
            LOCK: begin
                // arb_en is ignored here so an open burst always completes.
                grant_any = !reset && req[lock_idx] && headroom;
                gnt_idx   = lock_idx;
                if (grant_any && req_last[lock_idx]) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end
`else
    logic unused_req_last;

    assign unused_req_last = ^req_last;
    assign grant_any       = !reset && arb_en && rr_found && headroom;
    assign gnt_idx         = rr_idx;
    assign ptr_advance     = grant_any;
`endif

    always_comb begin
        gnt = '0;
        if (grant_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= LAST_IDX;
            wr_op   <= 1'b0;
            wr_data <= '0;
            arb_err <= 1'b0;
        end else begin
            wr_op <= grant_any;
            if (grant_any) begin
                wr_data <= req_data[int'(gnt_idx)*DAT_WIDTH +: DAT_WIDTH];
            end
            if (ptr_advance) begin
                rr_ptr <= gnt_idx;
            end
            if (wr_full_err) begin
                arb_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_generic_2clk_fifo_wr_arb.sv
// Self-checking bench for generic_2clk_fifo_wr_arb: reference model plus directed scenarios.
`default_nettype none

module tb_generic_2clk_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DW    = 36;
    localparam int PW    = 5;
    localparam int DEPTH = 32;

    logic               clk;
    logic               reset;
    logic               arb_en;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wr_op;
    logic [DW-1:0]      wr_data;
    logic [DW-1:0]      wr_mask;
    logic [PW:0]        wr_entry_used;
    logic               wr_full_err;
    logic               arb_err;

    int errors = 0;
    int checks = 0;
    int gq[$];
    logic [NREQ-1:0] last_gnt;

    // Reference model state
    int            m_ptr;
    logic          m_wr_op;
    logic [DW-1:0] m_wr_data;
    logic          m_err;
    logic          m_lock;
    int            m_lock_idx;

    generic_2clk_fifo_wr_arb #(
        .NUM_REQ(NREQ), .DAT_WIDTH(DW), .PTR_WIDTH(PW), .NUM_OF_ENTRIES(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en), .req(req), .req_last(req_last),
        .req_data(req_data), .gnt(gnt), .wr_op(wr_op), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_entry_used(wr_entry_used), .wr_full_err(wr_full_err),
        .arb_err(arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    // Which requester must be granted right now, or -1.
    function automatic int model_sel();
        if (reset) return -1;
        if ((int'(wr_entry_used) + int'(m_wr_op)) >= DEPTH) return -1;
        if (m_lock) return req[m_lock_idx] ? m_lock_idx : -1;
        if (!arb_en) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr      <= NREQ - 1;
            m_wr_op    <= 1'b0;
            m_wr_data  <= '0;
            m_err      <= 1'b0;
            m_lock     <= 1'b0;
            m_lock_idx <= 0;
        end else begin
            m_wr_op <= (model_sel() >= 0);
            if (model_sel() >= 0) begin
                m_wr_data <= data_of(model_sel());
                if (!m_lock) m_ptr <= model_sel();
`ifdef GENERIC_2CLK_FIFO_WR_ARB_BURST_EN
                if (!m_lock && !req_last[model_sel()]) begin
                    m_lock     <= 1'b1;
                    m_lock_idx <= model_sel();
                end
                if (m_lock && req_last[model_sel()]) m_lock <= 1'b0;
`endif
            end
            m_err <= m_err | wr_full_err;
        end
    end

    always @(negedge clk) begin
        check("gnt", 64'(gnt), (model_sel() >= 0) ? (64'd1 << model_sel()) : 64'd0);
        check("wr_op", 64'(wr_op), 64'(m_wr_op));
        check("wr_data", 64'(wr_data), 64'(m_wr_data));
        check("arb_err", 64'(arb_err), 64'(m_err));
        check("wr_mask", 64'(wr_mask), 64'h0000_000F_FFFF_FFFF);
    end

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
    end

    // One clock of stimulus time; also plays the FIFO, counting each landed write.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            logic w;
            @(negedge clk);
            w = wr_op;
            last_gnt = gnt;
            @(posedge clk);
            #2;
            if (!reset && w) wr_entry_used = wr_entry_used + 1'b1;
        end
    endtask

    task automatic set_data(input int phase);
        for (int i = 0; i < NREQ; i++)
            req_data[i*DW +: DW] = {4'hA, 8'(i), 8'(phase), 16'h5A5A};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        req_last = '1;
        arb_en = 1'b1;
        wr_full_err = 1'b0;
        wr_entry_used = '0;
        tick(1);
        reset = 1'b0;
        gq.delete();
    endtask

    function automatic int gq_at(input int k);
        return (gq.size() > k) ? gq[k] : 99;
    endfunction

`ifdef GENERIC_2CLK_FIFO_WR_ARB_BURST_EN
    task automatic burst_run(input bit drop, input int exp_g1_cycle);
        int b0;
        int g1_cycle;
        do_reset();
        set_data(7);
        req = 4'b0011;
        req_last = 4'b1110;
        b0 = 0;
        g1_cycle = -1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (last_gnt[0]) begin
                b0++;
                if (b0 == 2) req_last[0] = 1'b1;
                if (b0 == 3) req[0] = 1'b0;
            end
            if (last_gnt[1]) begin
                req[1] = 1'b0;
                g1_cycle = c;
            end
            if (drop && b0 == 1) arb_en = 1'b0;
            if (c == 6) arb_en = 1'b1;
        end
        check("burst_count", 64'(gq.size()), 64'd4);
        check("burst_b0", 64'(gq_at(0)), 64'd0);
        check("burst_b1", 64'(gq_at(1)), 64'd0);
        check("burst_b2", 64'(gq_at(2)), 64'd0);
        check("burst_next", 64'(gq_at(3)), 64'd1);
        check("burst_g1_cycle", 64'(g1_cycle), 64'(exp_g1_cycle));
    endtask
`endif

    initial begin
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        arb_en = 1'b1;
        req = '0;
        req_last = '1;
        req_data = '0;
        wr_entry_used = '0;
        wr_full_err = 1'b0;
        last_gnt = '0;
        tick(2);
        check("reset_gnt", 64'(gnt), 64'd0);
        check("reset_wr_op", 64'(wr_op), 64'd0);
        check("reset_wr_data", 64'(wr_data), 64'd0);
        check("reset_arb_err", 64'(arb_err), 64'd0);

        // Round robin with all requesters active
        reset = 1'b0;
        set_data(1);
        req = 4'b1111;
        gq.delete();
        tick(5);
        for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), 64'(gq_at(k)), 64'(exp_rr[k]));

        // Single requester fills the FIFO, then one drained entry allows one more write
        do_reset();
        set_data(2);
        req = 4'b0100;
        tick(40);
        check("fill_grants", 64'(gq.size()), 64'd32);
        check("fill_used", 64'(wr_entry_used), 64'd32);
        check("fill_arb_err", 64'(arb_err), 64'd0);
        gq.delete();
        wr_entry_used = wr_entry_used - 1'b1;
        tick(6);
        check("drain_grants", 64'(gq.size()), 64'd1);
        check("drain_used", 64'(wr_entry_used), 64'd32);

        // arb_en gating keeps the pointer in place
        do_reset();
        set_data(3);
        req = 4'b1111;
        tick(2);
        arb_en = 1'b0;
        tick(3);
        arb_en = 1'b1;
        tick(1);
        check("en_count", 64'(gq.size()), 64'd3);
        check("en_g0", 64'(gq_at(0)), 64'd0);
        check("en_g1", 64'(gq_at(1)), 64'd1);
        check("en_resume", 64'(gq_at(2)), 64'd2);

        // Sticky overflow flag
        do_reset();
        wr_full_err = 1'b1;
        tick(1);
        wr_full_err = 1'b0;
        tick(3);
        check("err_sticky", 64'(arb_err), 64'd1);
        do_reset();
        tick(1);
        check("err_cleared", 64'(arb_err), 64'd0);

`ifdef GENERIC_2CLK_FIFO_WR_ARB_BURST_EN
        burst_run(1'b0, 3);
        burst_run(1'b1, 7);
`else
        // Without burst support req_last has no effect: plain alternation
        do_reset();
        set_data(5);
        req = 4'b0011;
        req_last = 4'b0000;
        tick(4);
        check("nolock_g0", 64'(gq_at(0)), 64'd0);
        check("nolock_g1", 64'(gq_at(1)), 64'd1);
        check("nolock_g2", 64'(gq_at(2)), 64'd0);
        check("nolock_g3", 64'(gq_at(3)), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
